// File: rtl/pq_req_arbiter_if.sv
// Shared kv_t definitions and the bundle connecting requesters and the priority queue
// to pq_req_arbiter. The package sits here so the interface can use kv_t.
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam int  KV_W     = $bits(kv_t);
  localparam kv_t KV_EMPTY = '{key: '1, val: '0};
endpackage

interface pq_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import pq_pkg::*;

  logic [NUM_REQ-1:0]      req_enq;
  logic [NUM_REQ-1:0]      req_deq;
  logic [NUM_REQ*KV_W-1:0] req_kvi;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ-1:0]      err;
  kv_t                     rsp_kv;
  logic                    pq_enq;
  logic                    pq_deq;
  kv_t                     pq_kvi;
  kv_t                     pq_kvo;
  logic                    pq_busy;
  logic                    pq_full;
  logic                    pq_empty;

  // master is the environment: requesters plus the queue itself
  modport master (
    output req_enq, req_deq, req_kvi, pq_kvo, pq_busy, pq_full, pq_empty,
    input  done, err, rsp_kv, pq_enq, pq_deq, pq_kvi
  );

  modport slave (
    input  req_enq, req_deq, req_kvi, pq_kvo, pq_busy, pq_full, pq_empty,
    output done, err, rsp_kv, pq_enq, pq_deq, pq_kvi
  );
endinterface

// File: rtl/pq_req_arbiter.sv
// Round-robin arbiter serializing enqueue/dequeue/replace requests from NUM_REQ
// requesters onto a single-operation priority queue port.
module pq_req_arbiter
  import pq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  pq_req_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDW-1:0]     rr_reg, rr_next;
  logic [IDW-1:0]     gnt_reg, gnt_next;
  logic               op_enq_reg, op_enq_next;
  logic               op_deq_reg, op_deq_next;
  kv_t                kv_reg, kv_next;
  logic               errl_reg, errl_next;
  kv_t                rsp_kv_reg, rsp_kv_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic               pq_enq_reg, pq_enq_next;
  logic               pq_deq_reg, pq_deq_next;
  kv_t                pq_kvi_reg, pq_kvi_next;

  logic [NUM_REQ-1:0] pend;
  kv_t                kv_arr [NUM_REQ];
  logic [IDW-1:0]     cand   [NUM_REQ];
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic               illegal;

  // cand[k] is the k-th requester visited when searching upward from rr
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign pend[gi]   = bus.req_enq[gi] | bus.req_deq[gi];
    assign kv_arr[gi] = bus.req_kvi[gi*KV_W +: KV_W];
    assign cand[gi]   = IDW'((int'(rr_reg) + gi) % NUM_REQ);
  end

  // Descending scan so the candidate closest to rr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (pend[cand[k]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_next     = rr_reg;
    gnt_next    = gnt_reg;
    op_enq_next = op_enq_reg;
    op_deq_next = op_deq_reg;
    kv_next     = kv_reg;
    errl_next   = errl_reg;
    rsp_kv_next = rsp_kv_reg;
    illegal     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!bus.pq_busy && gnt_any) begin
          gnt_next    = gnt_idx;
          op_enq_next = bus.req_enq[gnt_idx];
          op_deq_next = bus.req_deq[gnt_idx];
          kv_next     = kv_arr[gnt_idx];
          rsp_kv_next = KV_EMPTY;
          // Replace needs a minimum to return but never grows the queue
          illegal     = (op_enq_next && !op_deq_next && bus.pq_full) ||
                        (op_deq_next && bus.pq_empty);
          errl_next   = illegal;
          state_next  = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (!bus.pq_busy) begin
          if (op_deq_reg) rsp_kv_next = bus.pq_kvo;
          state_next = RESP;
        end
      end
      RESP: begin
        rr_next    = (gnt_reg == IDW'(NUM_REQ - 1)) ? '0 : gnt_reg + IDW'(1);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    done_next = '0;
    err_next  = '0;
    if (state_next == RESP) begin
      done_next[gnt_next] = 1'b1;
      err_next[gnt_next]  = errl_next;
    end
    pq_enq_next = (state_next == ISSUE) && op_enq_next;
    pq_deq_next = (state_next == ISSUE) && op_deq_next;
    pq_kvi_next = (state_next == ISSUE) ? kv_next : pq_kvi_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_reg     <= '0;
      gnt_reg    <= '0;
      op_enq_reg <= 1'b0;
      op_deq_reg <= 1'b0;
      kv_reg     <= KV_EMPTY;
      errl_reg   <= 1'b0;
      rsp_kv_reg <= KV_EMPTY;
      done_reg   <= '0;
      err_reg    <= '0;
      pq_enq_reg <= 1'b0;
      pq_deq_reg <= 1'b0;
      pq_kvi_reg <= KV_EMPTY;
    end else begin
      state_reg  <= state_next;
      rr_reg     <= rr_next;
      gnt_reg    <= gnt_next;
      op_enq_reg <= op_enq_next;
      op_deq_reg <= op_deq_next;
      kv_reg     <= kv_next;
      errl_reg   <= errl_next;
      rsp_kv_reg <= rsp_kv_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      pq_enq_reg <= pq_enq_next;
      pq_deq_reg <= pq_deq_next;
      pq_kvi_reg <= pq_kvi_next;
    end
  end

  assign bus.done   = done_reg;
  assign bus.err    = err_reg;
  assign bus.rsp_kv = rsp_kv_reg;
  assign bus.pq_enq = pq_enq_reg;
  assign bus.pq_deq = pq_deq_reg;
  assign bus.pq_kvi = pq_kvi_reg;

endmodule

// File: tb/tb_pq_req_arbiter.sv
// Bench for pq_req_arbiter: a stub priority queue with programmable busy time, a
// queue-based reference model feeding a scoreboard, and a decoupled output monitor.
`timescale 1ns/1ps
module tb_pq_req_arbiter;
  import pq_pkg::*;

  localparam int N   = 4;
  localparam int CAP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pq_req_arbiter_if #(.NUM_REQ(N)) bus ();
  pq_req_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ---------------- stub priority queue ----------------
  kv_t st_mem [CAP];
  int  st_cnt = 0;
  int  st_bcnt = 0;
  bit  st_pend = 0, st_penq = 0, st_pdeq = 0;
  kv_t st_pkv;
  int  st_min;
  int  busy_len = 0;

  always_comb begin
    st_min = 0;
    for (int k = 1; k < CAP; k++)
      if (k < st_cnt && st_mem[k] < st_mem[st_min]) st_min = k;
  end

  assign bus.pq_kvo   = (st_cnt > 0) ? st_mem[st_min] : KV_EMPTY;
  assign bus.pq_busy  = (st_bcnt > 0);
  assign bus.pq_full  = (st_cnt == CAP);
  assign bus.pq_empty = (st_cnt == 0);

  always @(posedge clk) begin
    if (rst) begin
      st_cnt <= 0; st_bcnt <= 0; st_pend <= 0;
    end else if (bus.pq_enq || bus.pq_deq) begin
      st_pend <= 1; st_penq <= bus.pq_enq; st_pdeq <= bus.pq_deq;
      st_pkv  <= bus.pq_kvi; st_bcnt <= busy_len;
    end else if (st_bcnt > 0) begin
      st_bcnt <= st_bcnt - 1;
    end else if (st_pend) begin
      st_pend <= 0;
      if (st_penq && st_pdeq) st_mem[st_min] <= st_pkv;
      else if (st_pdeq && st_cnt > 0) begin
        st_mem[st_min] <= st_mem[st_cnt-1]; st_cnt <= st_cnt - 1;
      end else if (st_penq && st_cnt < CAP) begin
        st_mem[st_cnt] <= st_pkv; st_cnt <= st_cnt + 1;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int idx; bit err; kv_t kv; int cyc; } rsp_t;
  typedef struct { bit enq; bit deq; kv_t kv; int cyc; } stb_t;
  typedef struct { bit en; bit enq; bit deq; kv_t kv; } op_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  kv_t  mq[$];
  int   m_rr = 0;
  op_t  ops [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
  endtask

  task automatic model_reset();
    mq.delete(); rsp_q.delete(); stb_q.delete(); m_rr = 0;
  endtask

  // One granted operation starting at cycle t; returns the next possible grant cycle
  task automatic model_op(input int i, input int b, inout int t);
    rsp_t r;
    bit   legal;
    int   mi;
    if (ops[i].enq && !ops[i].deq) legal = (mq.size() < CAP);
    else legal = (mq.size() > 0);
    r.idx = i; r.err = !legal; r.kv = KV_EMPTY;
    if (legal) begin
      stb_q.push_back('{ops[i].enq, ops[i].deq, ops[i].kv, t + 1});
      if (ops[i].deq) begin
        mi = 0;
        foreach (mq[k]) if (mq[k] < mq[mi]) mi = k;
        r.kv = mq[mi];
        mq.delete(mi);
      end
      if (ops[i].enq) mq.push_back(ops[i].kv);
      r.cyc = t + 3 + b;
    end else begin
      r.cyc = t + 1;
    end
    rsp_q.push_back(r);
    t = r.cyc + 1;
    m_rr = (i + 1) % N;
  endtask

  task automatic clear_ops();
    for (int k = 0; k < N; k++) ops[k] = '{1'b0, 1'b0, 1'b0, KV_EMPTY};
  endtask

  task automatic set_op(input int i, input bit enq, input bit deq,
                        input logic [7:0] key, input logic [7:0] val);
    ops[i] = '{1'b1, enq, deq, kv_t'({key, val})};
  endtask

  task automatic clear_req(input int k);
    bus.req_enq[k] = 1'b0;
    bus.req_deq[k] = 1'b0;
  endtask

  // All enabled ops are raised together in one cycle the arbiter is idle
  task automatic run_round(input int b);
    int k0, t, ii, budget;
    logic [N-1:0] mask;
    @(negedge clk);
    busy_len = b; k0 = cyc; mask = '0;
    for (int k = 0; k < N; k++) begin
      if (ops[k].en) begin
        bus.req_enq[k] = ops[k].enq;
        bus.req_deq[k] = ops[k].deq;
        bus.req_kvi[k*KV_W +: KV_W] = ops[k].kv;
        mask[k] = 1'b1;
      end
    end
    t = k0;
    ii = m_rr;
    for (int s = 0; s < N; s++) begin
      if (ops[(ii + s) % N].en) model_op((ii + s) % N, b, t);
    end
    budget = 200;
    while (mask != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      for (int k = 0; k < N; k++)
        if (mask[k] && bus.done[k]) begin
          clear_req(k);
          mask[k] = 1'b0;
        end
    end
    chk("round_timeout_pending", 32'(mask), 32'd0);
    for (int k = 0; k < N; k++) clear_req(k);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_done"},   32'(bus.done),   32'd0);
    chk({tag, "_err"},    32'(bus.err),    32'd0);
    chk({tag, "_pq_enq"}, 32'(bus.pq_enq), 32'd0);
    chk({tag, "_pq_deq"}, 32'(bus.pq_deq), 32'd0);
    chk({tag, "_pq_kvi"}, 32'(bus.pq_kvi), 32'(KV_EMPTY));
    chk({tag, "_rsp_kv"}, 32'(bus.rsp_kv), 32'(KV_EMPTY));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < N; k++) clear_req(k);
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  rsp_t me;
  stb_t ms;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done != 0) begin
        $display("txn done=%b err=%b rsp_kv=%h cycle=%0d", bus.done, bus.err, bus.rsp_kv, cyc);
        if (rsp_q.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
        else begin
          me = rsp_q.pop_front();
          chk("done_onehot", 32'(bus.done), 32'(1) << me.idx);
          chk("err", 32'(bus.err), me.err ? (32'(1) << me.idx) : 32'd0);
          chk("rsp_kv", 32'(bus.rsp_kv), 32'(me.kv));
          chk("done_cycle", 32'(cyc), 32'(me.cyc));
        end
      end else if (bus.err != 0) begin
        chk("err_without_done", 32'(bus.err), 32'd0);
      end
      if (bus.pq_enq || bus.pq_deq) begin
        if (stb_q.size() == 0) chk("unexpected_strobe", {30'd0, bus.pq_enq, bus.pq_deq}, 32'd0);
        else begin
          ms = stb_q.pop_front();
          chk("pq_enq", 32'(bus.pq_enq), 32'(ms.enq));
          chk("pq_deq", 32'(bus.pq_deq), 32'(ms.deq));
          if (ms.enq) chk("pq_kvi", 32'(bus.pq_kvi), 32'(ms.kv));
          chk("strobe_cycle", 32'(cyc), 32'(ms.cyc));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k0;
    bus.req_enq = '0;
    bus.req_deq = '0;
    bus.req_kvi = '0;
    do_reset();

    // single enqueue, zero-latency queue
    clear_ops(); set_op(0, 1, 0, 8'h10, 8'h01); run_round(0);

    // fairness: all four, then 1 and 3 from rr=0
    do_reset();
    clear_ops();
    for (int k = 0; k < N; k++) set_op(k, 1, 0, 8'h41 + 8'(k), 8'(k));
    run_round(0);
    clear_ops(); set_op(1, 1, 0, 8'h51, 8'h11); set_op(3, 1, 0, 8'h53, 8'h33); run_round(2);

    // dequeue returns the minimum while busy stretches 4 cycles
    do_reset();
    clear_ops(); set_op(0, 1, 0, 8'h30, 8'h00); set_op(1, 1, 0, 8'h05, 8'h00);
    set_op(3, 1, 0, 8'h20, 8'h00); run_round(0);
    clear_ops(); set_op(2, 0, 1, 8'h00, 8'h00); run_round(4);

    // errors: dequeue when empty, enqueue when full
    do_reset();
    clear_ops(); set_op(2, 0, 1, 8'h77, 8'h77); run_round(0);
    clear_ops();
    for (int k = 0; k < N; k++) set_op(k, 1, 0, 8'h60 + 8'(k), 8'h00);
    run_round(1);
    clear_ops();
    for (int k = 0; k < N; k++) set_op(k, 1, 0, 8'h70 + 8'(k), 8'h00);
    run_round(0);

    // replace
    do_reset();
    clear_ops(); set_op(0, 1, 0, 8'h08, 8'hAA); run_round(0);
    clear_ops(); set_op(1, 1, 1, 8'h40, 8'h01); run_round(1);

    // reset during WAIT: leave rr at 2, abandon requester 3, then expect rr back at 0
    do_reset();
    clear_ops(); set_op(1, 1, 0, 8'h11, 8'h22); run_round(0);
    @(negedge clk);
    k0 = cyc;
    busy_len = 6;
    bus.req_kvi[3*KV_W +: KV_W] = kv_t'(16'h5555);
    bus.req_deq[3] = 1'b1;
    stb_q.push_back('{1'b0, 1'b1, KV_EMPTY, k0 + 1});
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_req(3);
    @(negedge clk);
    check_reset_vals("midop");
    rst = 1'b0;
    model_reset();
    clear_ops();
    for (int k = 0; k < N; k++) set_op(k, 1, 0, 8'h90 - 8'(k), 8'h5A);
    run_round(0);

    // randomized rounds
    for (int r = 0; r < 60; r++) begin
      clear_ops();
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          case ($urandom_range(2, 0))
            0: set_op(k, 1, 0, 8'($urandom), 8'($urandom));
            1: set_op(k, 0, 1, 8'($urandom), 8'($urandom));
            default: set_op(k, 1, 1, 8'($urandom), 8'($urandom));
          endcase
        end
      end
      if (!(ops[0].en || ops[1].en || ops[2].en || ops[3].en))
        set_op(int'($urandom_range(N - 1, 0)), 1, 0, 8'($urandom), 8'($urandom));
      run_round(int'($urandom_range(3, 0)));
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(rsp_q.size() + stb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pq_req_arbiter.md
# pq_req_arbiter

Round-robin arbiter that shares one hardware priority queue among NUM_REQ independent requesters. Each requester posts enqueue, dequeue or replace operations on kv_t <key,value> pairs (pq_pkg). The arbiter serializes them onto the queue's single-operation port, waits for the queue to finish, and returns the dequeued pair or an error to the requester. It sits between client logic and any HWPQ implementation that uses the standard pq_pkg interface.

## Interface
- NUM_REQ, 4: number of requester ports (2..16).
- IDW, $clog2(NUM_REQ): width of the requester index.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_enq  in  NUM_REQ  per-requester enqueue request; level, held until done.
- req_deq  in  NUM_REQ  per-requester dequeue request; level, held until done.
- req_kvi  in  NUM_REQ*$bits(kv_t)  per-requester kv_t to enqueue; slice i belongs to requester i.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- err  out  NUM_REQ  one-cycle, coincident with done; marks a rejected op.
- rsp_kv  out  kv_t  dequeued pair; valid while any done bit is 1.
- pq_enq  out  1  one-cycle enqueue strobe to the queue.
- pq_deq  out  1  one-cycle dequeue strobe to the queue.
- pq_kvi  out  kv_t  pair presented to the queue; valid with pq_enq.
- pq_kvo  in  kv_t  queue's minimum-key pair.
- pq_busy  in  1  queue is processing an operation.
- pq_full  in  1  queue holds PQ_CAPACITY entries.
- pq_empty  in  1  queue holds no entries.

## Operation
- Op decode for requester i: enq only gives ENQ. deq only gives DEQ. Both give REPL (pq_enq and pq_deq strobed together; returns the old minimum and inserts req_kvi[i]).
- Arbitration: round-robin pointer rr. Grant goes to the first requester with a nonzero op, searching from rr upward with wrap. After done for requester g, rr becomes (g+1) mod NUM_REQ.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: if pq_busy=0 and any request is pending, latch g, the op and req_kvi[g], then check legality:
  - ENQ with pq_full=1 is illegal.
  - DEQ or REPL with pq_empty=1 is illegal.
  - Illegal: go to RESP with err set.
  - Legal: go to ISSUE.
- ISSUE: drive pq_enq and/or pq_deq high for exactly this cycle, pq_kvi = latched pair. Go to WAIT.
- WAIT: stay while pq_busy=1. On pq_busy=0, capture pq_kvo into rsp_kv if the op is DEQ or REPL, and go to RESP.
- RESP: done[g]=1 and err[g] as latched, for one cycle. rsp_kv holds the captured pair; it is KV_EMPTY for ENQ and for errors. Update rr and go to IDLE.
- Requester i must deassert its request in the cycle after done[i]. Changing req_kvi or the op while waiting for done is not allowed.
- Requests that arrive while the FSM is not in IDLE stay pending; none are lost.
- Reset mid-operation abandons the op with no done pulse. The queue is reset by the same rst.

## Timing
- Reset values: done=0, err=0, pq_enq=0, pq_deq=0, pq_kvi=KV_EMPTY, rsp_kv=KV_EMPTY, rr=0, state IDLE.
- All outputs are registered.
- Legal op latency, from the IDLE grant cycle to done: 3 + B cycles, where B is the number of cycles pq_busy stays high after the strobe. B=0 gives done 3 cycles after grant.
- Illegal op latency: done/err 1 cycle after grant. No queue strobe is issued.
- Full/empty are sampled only in the IDLE grant cycle.
- Throughput: at most one queue op in flight. The next grant is possible in the cycle after RESP.

## Test plan
- Single enqueue, queue empty, zero-latency queue: requester 0 sends key=0x10, val=0x01. Expect one pq_enq pulse with pq_kvi={0x10,0x01}, then done[0] 3 cycles after grant with err[0]=0 and rsp_kv=KV_EMPTY.
- Round-robin fairness: requesters 0..3 all raise ENQ in the same cycle after reset. Grants go in order 0,1,2,3. Re-raising 1 and 3 together after the previous round (rr=0) grants 1 then 3.
- Dequeue after enqueues: enqueue keys 0x30, 0x05, 0x20, then requester 2 dequeues. Expect done[2] with rsp_kv.key=0x05 while pq_busy stretches 4 cycles, and done exactly when busy drops.
- Errors: DEQ with pq_empty=1 gives done and err in the cycle after grant, rsp_kv=0xFF00, no strobe. ENQ with pq_full=1 gives the same with no pq_enq.
- REPL: queue holds {0x08,0xAA}. Requester 1 sets both enq and deq with {0x40,0x01}. Expect pq_enq and pq_deq high in the same cycle, then rsp_kv={0x08,0xAA}.
- Reset mid-op: assert rst during WAIT. Expect no done pulse, all outputs at reset values next cycle, and rr=0.
